// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU, iterative multiply and EX/MEM register.
// Ports:
//   clock, reset (async, active-low), flush (sync bubble + multiply abort)
//   in*        : ID/EX control bits, data and register addresses
//   wb*        : writeback-stage forwarding source
//   stall      : combinational hold request while a multiply is in flight
//   out*       : EX/MEM pipeline register contents
module ex_stage #(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        inRegWriteEn,
   input  logic        inMemWriteEn,
   input  logic        inMemReadEn,
   input  logic        inALUSrc,
   input  logic [1:0]  inMemtoReg,
   input  logic [2:0]  inALUOp,
   input  logic [1:0]  inRegDst,
   input  logic [31:0] inNextPC,
   input  logic [31:0] inreadData1,
   input  logic [31:0] inreadData2,
   input  logic [31:0] inimmediateExtended,
   input  logic [4:0]  inRsAddress,
   input  logic [4:0]  inRtAddress,
   input  logic [4:0]  inRdAddress,
   input  logic        wbRegWriteEn,
   input  logic [4:0]  wbWriteAddress,
   input  logic [31:0] wbWriteData,
   output logic        stall,
   output logic        outRegWriteEn,
   output logic        outMemWriteEn,
   output logic        outMemReadEn,
   output logic [1:0]  outMemtoReg,
   output logic [31:0] outALUResult,
   output logic [31:0] outStoreData,
   output logic [31:0] outNextPC,
   output logic [4:0]  outWriteAddress
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      state;
   logic [5:0]  count;
   logic [31:0] mcand, mplier, prod;
   logic [31:0] ex_fwd, fwd_a, fwd_b, op_b, alu_res;
   logic [4:0]  dst;
   logic        is_mul, ex_ok, load_en;

   assign is_mul = inALUOp == 3'b111;
   assign stall  = is_mul && state != DONE;
   // EX/MEM may forward only ALU results or link addresses, never pending load data
   assign ex_ok  = outRegWriteEn && !outMemReadEn && outWriteAddress != 5'd0;
   assign ex_fwd = (outMemtoReg == 2'b10) ? outNextPC : outALUResult;
   assign fwd_a  = (ex_ok && outWriteAddress == inRsAddress) ? ex_fwd :
                   (wbRegWriteEn && wbWriteAddress != 5'd0 && wbWriteAddress == inRsAddress) ? wbWriteData :
                   inreadData1;
   assign fwd_b  = (ex_ok && outWriteAddress == inRtAddress) ? ex_fwd :
                   (wbRegWriteEn && wbWriteAddress != 5'd0 && wbWriteAddress == inRtAddress) ? wbWriteData :
                   inreadData2;
   assign op_b   = inALUSrc ? inimmediateExtended : fwd_b;
   assign dst    = (inRegDst == 2'b00) ? inRtAddress : (inRegDst == 2'b10) ? 5'd31 : inRdAddress;
   // Real results land only in IDLE on a non-multiply or in DONE; everything else is a bubble
   assign load_en = !flush && (state == DONE || (state == IDLE && !is_mul));

   always_comb begin
      alu_res = 32'd0;
      case (inALUOp)
         3'b000: alu_res = fwd_a + op_b;
         3'b001: alu_res = fwd_a - op_b;
         3'b010: alu_res = fwd_a & op_b;
         3'b011: alu_res = fwd_a | op_b;
         3'b100: alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
         3'b101: alu_res = fwd_a ^ op_b;
         3'b110: alu_res = ~(fwd_a | op_b);
         default: alu_res = prod;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         count  <= 6'd0;
         mcand  <= 32'd0;
         mplier <= 32'd0;
         prod   <= 32'd0;
      end else if (flush) begin
         state <= IDLE;
         count <= 6'd0;
      end else begin
         case (state)
            IDLE: if (is_mul) begin
               mcand  <= fwd_a;
               mplier <= op_b;
               prod   <= 32'd0;
               count  <= 6'd0;
               state  <= BUSY;
            end
            BUSY: begin
               prod   <= prod + (mplier[0] ? mcand : 32'd0);
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 6'd1;
               if (count == 6'(MUL_CYCLES - 1)) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outRegWriteEn   <= 1'b0;
         outMemWriteEn   <= 1'b0;
         outMemReadEn    <= 1'b0;
         outMemtoReg     <= 2'd0;
         outALUResult    <= 32'd0;
         outStoreData    <= 32'd0;
         outNextPC       <= 32'd0;
         outWriteAddress <= 5'd0;
      end else begin
         outRegWriteEn   <= load_en ? inRegWriteEn : 1'b0;
         outMemWriteEn   <= load_en ? inMemWriteEn : 1'b0;
         outMemReadEn    <= load_en ? inMemReadEn : 1'b0;
         outMemtoReg     <= load_en ? inMemtoReg : 2'd0;
         outALUResult    <= load_en ? alu_res : 32'd0;
         outStoreData    <= load_en ? fwd_b : 32'd0;
         outNextPC       <= load_en ? inNextPC : 32'd0;
         outWriteAddress <= load_en ? dst : 5'd0;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
   logic        clock, reset, flush;
   logic        inRegWriteEn, inMemWriteEn, inMemReadEn, inALUSrc;
   logic [1:0]  inMemtoReg, inRegDst;
   logic [2:0]  inALUOp;
   logic [31:0] inNextPC, inreadData1, inreadData2, inimmediateExtended;
   logic [4:0]  inRsAddress, inRtAddress, inRdAddress;
   logic        wbRegWriteEn;
   logic [4:0]  wbWriteAddress;
   logic [31:0] wbWriteData;
   logic        stall, outRegWriteEn, outMemWriteEn, outMemReadEn;
   logic [1:0]  outMemtoReg;
   logic [31:0] outALUResult, outStoreData, outNextPC;
   logic [4:0]  outWriteAddress;
   int          checks = 0, errors = 0;
   int          n, bad;

   ex_stage dut (
      .clock(clock), .reset(reset), .flush(flush),
      .inRegWriteEn(inRegWriteEn), .inMemWriteEn(inMemWriteEn), .inMemReadEn(inMemReadEn),
      .inALUSrc(inALUSrc), .inMemtoReg(inMemtoReg), .inALUOp(inALUOp), .inRegDst(inRegDst),
      .inNextPC(inNextPC), .inreadData1(inreadData1), .inreadData2(inreadData2),
      .inimmediateExtended(inimmediateExtended), .inRsAddress(inRsAddress),
      .inRtAddress(inRtAddress), .inRdAddress(inRdAddress), .wbRegWriteEn(wbRegWriteEn),
      .wbWriteAddress(wbWriteAddress), .wbWriteData(wbWriteData), .stall(stall),
      .outRegWriteEn(outRegWriteEn), .outMemWriteEn(outMemWriteEn), .outMemReadEn(outMemReadEn),
      .outMemtoReg(outMemtoReg), .outALUResult(outALUResult), .outStoreData(outStoreData),
      .outNextPC(outNextPC), .outWriteAddress(outWriteAddress)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic nop();
      {inRegWriteEn, inMemWriteEn, inMemReadEn, inALUSrc} = 4'b0;
      inMemtoReg = 2'd0; inALUOp = 3'd0; inRegDst = 2'd0;
      inNextPC = 32'd0; inreadData1 = 32'd0; inreadData2 = 32'd0; inimmediateExtended = 32'd0;
      inRsAddress = 5'd0; inRtAddress = 5'd0; inRdAddress = 5'd0;
      wbRegWriteEn = 1'b0; wbWriteAddress = 5'd0; wbWriteData = 32'd0;
   endtask

   // R-type style instruction: Rs=rs, Rt=rt, Rd=rd with RegDst=01
   task automatic rop(input logic [2:0] op, input logic we, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
      inALUOp = op; inRegWriteEn = we; inRegDst = 2'b01;
      inRsAddress = rs; inRtAddress = rt; inRdAddress = rd;
      inreadData1 = a; inreadData2 = b;
   endtask

   // Counts edges until stall drops, flagging any non-bubble EX/MEM seen meanwhile
   task automatic wait_mul(output int cyc, output int nb);
      cyc = 0; nb = 0;
      while (stall && cyc < 40) begin
         tick();
         cyc++;
         if (outRegWriteEn || outMemWriteEn || outMemReadEn || outALUResult != 32'd0) nb++;
      end
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; nop();
      tick(); tick();
      chk("reset_regwrite", {31'd0, outRegWriteEn}, 32'd0);
      chk("reset_alu", outALUResult, 32'd0);
      reset = 1'b1;
      tick();
      chk("post_reset_waddr", {27'd0, outWriteAddress}, 32'd0);
      chk("post_reset_stall", {31'd0, stall}, 32'd0);
      // ADD r3 = 5 + 7
      rop(3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
      tick();
      chk("add_res", outALUResult, 32'd12);
      chk("add_waddr", {27'd0, outWriteAddress}, 32'd3);
      chk("add_we", {31'd0, outRegWriteEn}, 32'd1);
      // EX/MEM r4=100 beats WB r4=55
      rop(3'b000, 1'b1, 5'd1, 5'd2, 5'd4, 32'd60, 32'd40);
      tick();
      rop(3'b001, 1'b1, 5'd4, 5'd5, 5'd6, 32'd999, 32'd1);
      wbRegWriteEn = 1'b1; wbWriteAddress = 5'd4; wbWriteData = 32'd55;
      tick();
      chk("fwd_ex_priority", outALUResult, 32'd99);
      tick();
      chk("fwd_wb_only", outALUResult, 32'd54);
      // r0 is never forwarded
      rop(3'b000, 1'b1, 5'd1, 5'd2, 5'd0, 32'd10, 32'd20);
      wbRegWriteEn = 1'b0;
      tick();
      rop(3'b001, 1'b1, 5'd0, 5'd5, 5'd6, 32'd50, 32'd1);
      wbRegWriteEn = 1'b1; wbWriteAddress = 5'd0; wbWriteData = 32'd77;
      tick();
      chk("fwd_r0", outALUResult, 32'd49);
      wbRegWriteEn = 1'b0;
      // a load in EX/MEM is not forwarded
      rop(3'b000, 1'b1, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4);
      inMemReadEn = 1'b1;
      tick();
      chk("load_memread", {31'd0, outMemReadEn}, 32'd1);
      rop(3'b000, 1'b0, 5'd1, 5'd7, 5'd9, 32'd1, 32'd2);
      inMemReadEn = 1'b0;
      tick();
      chk("no_fwd_load", outALUResult, 32'd3);
      // operand B forwarding and store data, then immediate select
      rop(3'b000, 1'b1, 5'd1, 5'd2, 5'd8, 32'd5, 32'd5);
      tick();
      rop(3'b000, 1'b0, 5'd1, 5'd8, 5'd9, 32'd1, 32'd0);
      tick();
      chk("fwd_b_res", outALUResult, 32'd11);
      chk("fwd_b_store", outStoreData, 32'd10);
      rop(3'b000, 1'b0, 5'd1, 5'd8, 5'd9, 32'd1, 32'h22);
      inALUSrc = 1'b1; inimmediateExtended = 32'h100;
      tick();
      chk("imm_res", outALUResult, 32'h101);
      chk("imm_store", outStoreData, 32'h22);
      inALUSrc = 1'b0;
      // logic ops
      rop(3'b010, 1'b0, 5'd1, 5'd2, 5'd9, 32'hF0F0_00FF, 32'h0FF0_0F0F);
      tick(); chk("and", outALUResult, 32'h00F0_000F);
      inALUOp = 3'b011; tick(); chk("or", outALUResult, 32'hFFF0_0FFF);
      inALUOp = 3'b101; tick(); chk("xor", outALUResult, 32'hFF00_0FF0);
      inALUOp = 3'b110; tick(); chk("nor", outALUResult, 32'h000F_F000);
      // signed SLT
      rop(3'b100, 1'b0, 5'd1, 5'd2, 5'd9, 32'hFFFF_FFFF, 32'd1);
      tick(); chk("slt_neg_lt_pos", outALUResult, 32'd1);
      rop(3'b100, 1'b0, 5'd1, 5'd2, 5'd9, 32'd1, 32'hFFFF_FFFF);
      tick(); chk("slt_pos_lt_neg", outALUResult, 32'd0);
      // jal: link to r31 with NextPC, dependent use forwards NextPC
      rop(3'b000, 1'b1, 5'd1, 5'd2, 5'd9, 32'd0, 32'd0);
      inRegDst = 2'b10; inMemtoReg = 2'b10; inNextPC = 32'h40;
      tick();
      chk("jal_waddr", {27'd0, outWriteAddress}, 32'd31);
      chk("jal_nextpc", outNextPC, 32'h40);
      rop(3'b000, 1'b0, 5'd31, 5'd1, 5'd9, 32'd0, 32'd4);
      inMemtoReg = 2'b00; inNextPC = 32'd0;
      tick();
      chk("jal_fwd", outALUResult, 32'h44);
      // MUL 0xFFFFFFFF * 3
      rop(3'b111, 1'b1, 5'd11, 5'd12, 5'd13, 32'hFFFF_FFFF, 32'd3);
      #1;
      chk("mul_stall_start", {31'd0, stall}, 32'd1);
      wait_mul(n, bad);
      chk("mul_stall_cycles", n, 32'd33);
      chk("mul_bubbles", bad, 32'd0);
      tick();
      chk("mul_res", outALUResult, 32'hFFFF_FFFD);
      chk("mul_we", {31'd0, outRegWriteEn}, 32'd1);
      chk("mul_waddr", {27'd0, outWriteAddress}, 32'd13);
      nop();
      // flush during BUSY at count=15
      rop(3'b111, 1'b1, 5'd11, 5'd12, 5'd13, 32'd6, 32'd7);
      for (int i = 0; i < 16; i++) tick();
      flush = 1'b1;
      rop(3'b000, 1'b1, 5'd1, 5'd2, 5'd9, 32'd1, 32'd1);
      tick();
      chk("flush_we", {31'd0, outRegWriteEn}, 32'd0);
      chk("flush_alu", outALUResult, 32'd0);
      chk("flush_stall", {31'd0, stall}, 32'd0);
      flush = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (outALUResult != 32'd2 || !outRegWriteEn || stall) bad++;
      end
      chk("flush_resume", bad, 32'd0);
      // reset mid-BUSY at count=10, then clean multiply with late WB noise
      rop(3'b111, 1'b1, 5'd11, 5'd12, 5'd14, 32'd6, 32'd7);
      for (int i = 0; i < 11; i++) tick();
      reset = 1'b0;
      nop();
      #1;
      chk("rst_mid_we", {31'd0, outRegWriteEn}, 32'd0);
      chk("rst_mid_stall", {31'd0, stall}, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("rst_mid_alu", outALUResult, 32'd0);
      rop(3'b111, 1'b1, 5'd11, 5'd12, 5'd14, 32'd6, 32'd7);
      tick();
      wbRegWriteEn = 1'b1; wbWriteAddress = 5'd11; wbWriteData = 32'd100;
      wait_mul(n, bad);
      chk("mul2_stall_cycles", n, 32'd32);
      tick();
      chk("mul2_res", outALUResult, 32'd42);
      chk("mul2_waddr", {27'd0, outWriteAddress}, 32'd14);
      nop();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined processor. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Performs operand forwarding, ALU/immediate operand select, destination-register select, and a 32-cycle iterative multiply.
- Contains the EX/MEM pipeline register. Its outputs feed the memory stage.
- Drives a stall request to the hazard unit while a multiply is in progress.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for ALUOp 111. Must equal the data width.

Ports:
- clock  in  1  system clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; inserts a bubble into EX/MEM and aborts any multiply.
- inRegWriteEn, inMemWriteEn, inMemReadEn, inALUSrc  in  1 each  control bits from ID/EX.
- inMemtoReg  in  2  writeback select (10 = NextPC).
- inALUOp  in  3  ALU operation.
- inRegDst  in  2  destination select.
- inNextPC, inreadData1, inreadData2, inimmediateExtended  in  32 each  data from ID/EX.
- inRsAddress, inRtAddress, inRdAddress  in  5 each  register addresses.
- wbRegWriteEn  in  1  writeback-stage write enable.
- wbWriteAddress  in  5  writeback destination register.
- wbWriteData  in  32  writeback value.
- stall  out  1  combinational; hold PC, IF/ID and ID/EX.
- outRegWriteEn, outMemWriteEn, outMemReadEn  out  1 each  EX/MEM control bits.
- outMemtoReg  out  2  EX/MEM writeback select.
- outALUResult, outStoreData, outNextPC  out  32 each  EX/MEM data.
- outWriteAddress  out  5  EX/MEM destination register.

Behaviour:
- Reset: asynchronous, active-low. All EX/MEM outputs go to 0, the FSM goes to IDLE, the iteration counter and multiply registers clear. Reset mid-multiply discards the multiply.
- Forwarding, operand A (Rs):
  - Use EX/MEM when outRegWriteEn=1, outMemReadEn=0, outWriteAddress!=0 and outWriteAddress==Rs. The forwarded value is outNextPC when outMemtoReg==10, otherwise outALUResult.
  - Otherwise use WB when wbRegWriteEn=1, wbWriteAddress!=0 and wbWriteAddress==Rs.
  - Otherwise use inreadData1.
  - EX/MEM has priority over WB. Register 0 is never forwarded.
- Forwarding, operand B (Rt): same rules, producing fwdB.
- Operands: opB = inALUSrc ? inimmediateExtended : fwdB. outStoreData captures fwdB.
- ALU (32-bit, overflow ignored):
  - 000 ADD, 001 SUB, 010 AND, 011 OR.
  - 100 SLT, signed: result is 1 or 0.
  - 101 XOR, 110 NOR.
  - 111 MUL: low 32 bits of the product.
- Destination (RegDst): 00 selects Rt, 01 selects Rd, 10 selects 5'd31, 11 selects Rd.
- Non-multiply ops have single-cycle latency: the EX/MEM register captures the result and all control signals at the next edge.
- Multiply FSM, states IDLE, BUSY, DONE:
  - stall = (inALUOp==111) && state!=DONE.
  - IDLE with ALUOp 111: latch forwarded opA and opB, count=0, go to BUSY. EX/MEM loads a bubble.
  - BUSY: one shift-add iteration per cycle and count increments. When count reaches MUL_CYCLES, go to DONE. EX/MEM loads a bubble each BUSY cycle.
  - DONE: stall=0. The next edge loads the product plus the ID/EX control signals (still held) into EX/MEM, then the FSM returns to IDLE.
  - Total: stall is high for 33 cycles; the product reaches EX/MEM 34 edges after the multiply first appears in EX.
  - Operands are latched once at start, so later WB changes do not affect the result.
- Bubble: all EX/MEM outputs are 0 (RegWriteEn, MemWriteEn and MemReadEn low).
- Flush: has priority over everything except reset. The next edge loads a bubble into EX/MEM and forces the FSM to IDLE, and stall drops that cycle. A flush during BUSY or DONE aborts the multiply with no writeback.
- A multiply following a multiply back-to-back restarts from IDLE after the DONE edge. There is no overlap.
- Load-use hazards are detected upstream. This block never forwards memory-read data.

Test Plan:
- Reset mid-BUSY (count=10): deassert reset -> outputs 0, stall=0, state IDLE. Re-issue MUL 6*7 -> outALUResult=42.
- ADD r3=r1+r2 with readData1=5, readData2=7, RegDst=01, Rd=3 -> after 1 edge outALUResult=12, outWriteAddress=3, outRegWriteEn=1.
- Forwarding priority: EX/MEM holds r4=100 and WB writes r4=55. Next instruction SUB Rs=4 with readData2=1 -> 99. Repeat with Rs=0 and forwarders targeting r0 -> uses inreadData1.
- MUL 0xFFFFFFFF*3 -> stall high 33 cycles, EX/MEM bubbles meanwhile, then outALUResult=0xFFFFFFFD, outRegWriteEn=1 on edge 34.
- Flush during BUSY (count=15) -> next edge EX/MEM bubble, stall=0, no writeback of the product.
- SLT signed: opA=0xFFFFFFFF, opB=1 -> 1. jal-style RegDst=10, MemtoReg=10 with NextPC=0x40 -> outWriteAddress=31, and a dependent Rs=31 forwards 0x40.
